// File: rtl/frame_scanout.sv
// Raster scan-out engine: walks a fixed video timing, reads pixels from
// frame memory and presents them with aligned data-enable and syncs.
module frame_scanout #(
  parameter int H_ACTIVE = 400,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 225,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 8,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_init_done,
  output logic       o_rd_en,
  output logic [8:0] o_rd_x,
  output logic [7:0] o_rd_y,
  input  logic [5:0] i_rd_data,
  output logic [5:0] o_rgb,
  output logic       o_de,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_frame_start,
  output logic [7:0] o_frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_VIS  = 9'(H_ACTIVE);
  localparam logic [8:0] HS_BEG = 9'(H_ACTIVE + H_FP);
  localparam logic [8:0] HS_END = 9'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [7:0] V_LAST = 8'(V_TOTAL - 1);
  localparam logic [7:0] V_VIS  = 8'(V_ACTIVE);
  localparam logic [7:0] VS_BEG = 8'(V_ACTIVE + V_FP);
  localparam logic [7:0] VS_END = 8'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] h_q, h_d;
  logic [7:0] v_q, v_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       run;

  // Flag order in stage bundles: {visible, hsync, vsync, frame_start}
  logic [3:0] s0;
  logic [3:0] s1_q;
  logic [3:0] s2_q;
  logic       rd_en_q;
  logic [8:0] rd_x_q;
  logic [7:0] rd_y_q;
  logic [5:0] rgb_q;
  logic       de_q;
  logic       hs_q;
  logic       vs_q;
  logic       fs_q;

  assign run = (state_q == SCAN);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    h_d     = '0;
    v_d     = '0;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (i_init_done) state_d = SCAN;
      end
      SCAN: begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d    = '0;
            fcnt_d = fcnt_q + 8'd1;
          end else begin
            v_d = v_q + 8'd1;
          end
        end else begin
          h_d = h_q + 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s0    = '0;
    s0[3] = run && (h_q < H_VIS) && (v_q < V_VIS);
    s0[2] = run && (h_q >= HS_BEG) && (h_q < HS_END);
    s0[1] = run && (v_q >= VS_BEG) && (v_q < VS_END);
    s0[0] = run && (h_q == '0) && (v_q == '0);
  end

  // Memory answers one clock after the strobe, so the pixel is
  // captured straight into the output register at stage 3.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q     <= '0;
      v_q     <= '0;
      fcnt_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      rd_en_q <= 1'b0;
      rd_x_q  <= '0;
      rd_y_q  <= '0;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hs_q    <= !SYNC_POL;
      vs_q    <= !SYNC_POL;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      fcnt_q  <= fcnt_d;
      s1_q    <= s0;
      s2_q    <= s1_q;
      rd_en_q <= s0[3];
      if (s0[3]) begin
        rd_x_q <= h_q;
        rd_y_q <= v_q;
      end
      rgb_q <= s2_q[3] ? i_rd_data : 6'd0;
      de_q  <= s2_q[3];
      hs_q  <= s2_q[2] ? SYNC_POL : !SYNC_POL;
      vs_q  <= s2_q[1] ? SYNC_POL : !SYNC_POL;
      fs_q  <= s2_q[0];
    end
  end

  assign o_rd_en       = rd_en_q;
  assign o_rd_x        = rd_x_q;
  assign o_rd_y        = rd_y_q;
  assign o_rgb         = rgb_q;
  assign o_de          = de_q;
  assign o_hsync       = hs_q;
  assign o_vsync       = vs_q;
  assign o_frame_start = fs_q;
  assign o_frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout on a reduced timing so many frames fit:
// phase table with expected pixel/pulse counts, a positional model, corner sequences.
module tb_frame_scanout;

  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HB  = 3;
  localparam int VA  = 5;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VB  = 2;
  localparam int HT  = HA + HFP + HS + HB;
  localparam int VT  = VA + VFP + VS + VB;
  localparam int FT  = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init = 1'b0;
  logic [5:0] rd_data = '0;
  logic       o_rd_en;
  logic [8:0] o_rd_x;
  logic [7:0] o_rd_y;
  logic [5:0] o_rgb;
  logic       o_de;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_frame_start;
  logic [7:0] o_frame_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_init_done  (init),
    .o_rd_en      (o_rd_en),
    .o_rd_x       (o_rd_x),
    .o_rd_y       (o_rd_y),
    .i_rd_data    (rd_data),
    .o_rgb        (o_rgb),
    .o_de         (o_de),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_frame_start(o_frame_start),
    .o_frame_cnt  (o_frame_cnt)
  );

  // Frame memory holds x^y; data valid one clock after the strobe.
  always @(posedge clk)
    if (o_rd_en) rd_data <= 6'(o_rd_x ^ 9'(o_rd_y));

  // Positional model: k = clocks elapsed since the scan-start edge.
  bit         m_scan = 0;
  bit         m_valid = 0;
  int         m_k = 0;
  int         m_rdx = 0;
  int         m_rdy = 0;
  int         p, x, y;
  bit         e_rden, e_de, e_hs, e_vs, e_fs;
  logic [5:0] e_rgb;
  logic [7:0] e_fcnt;

  always @(posedge clk) begin
    if (rst) begin
      m_scan = 0; m_k = 0; m_rdx = 0; m_rdy = 0;
    end else if (!m_scan) begin
      if (init) begin m_scan = 1; m_k = 0; end
    end else begin
      m_k = m_k + 1;
    end
    e_rden = 0;
    if (m_scan && m_k >= 1) begin
      p = m_k - 1; x = p % HT; y = (p / HT) % VT;
      if (x < HA && y < VA) begin
        e_rden = 1; m_rdx = x; m_rdy = y;
      end
    end
    e_de = 0; e_rgb = '0; e_hs = 0; e_vs = 0; e_fs = 0;
    if (m_scan && m_k >= 3) begin
      p = m_k - 3; x = p % HT; y = (p / HT) % VT;
      e_de  = (x < HA) && (y < VA);
      e_rgb = e_de ? 6'(x ^ y) : 6'd0;
      e_hs  = (x >= HA + HFP) && (x < HA + HFP + HS);
      e_vs  = (y >= VA + VFP) && (y < VA + VFP + VS);
      e_fs  = (p % FT) == 0;
    end
    e_fcnt  = m_scan ? 8'((m_k / FT) % 256) : 8'd0;
    m_valid = 1;
  end

  logic [35:0] act_v, exp_v;

  always @(negedge clk) begin
    if (m_valid) begin
      act_v = {o_rd_en, o_rd_x, o_rd_y, o_rgb, o_de,
               o_hsync, o_vsync, o_frame_start, o_frame_cnt};
      exp_v = {e_rden, 9'(m_rdx), 8'(m_rdy), e_rgb, e_de,
               ~e_hs, ~e_vs, e_fs, e_fcnt};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model t=%0t actual=%h required=%h",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic cyc(input bit r, input bit in);
    rst  = r;
    init = in;
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode 0: fixed inputs, 1: random init, 2: random init + rare reset
  typedef struct {
    bit r;
    bit in;
    int mode;
    int n;
    int exp_de;
    int exp_fs;
  } vec_t;

  vec_t tbl[6];
  int   cnt_de, cnt_fs, last_fs, npulses;
  bit   found, wrapped, rr, ii;
  logic [7:0] prev_fc;

  initial begin
    tbl[0] = '{1, 0, 0, 4,    0,   0};
    tbl[1] = '{0, 0, 0, 100,  0,   0};
    tbl[2] = '{0, 1, 0, 1,    0,   0};
    tbl[3] = '{0, 0, 0, 320,  80,  2};
    tbl[4] = '{0, 0, 1, 1000, 262, 7};
    tbl[5] = '{0, 0, 2, 2000, -1,  -1};

    for (int i = 0; i < 6; i++) begin
      cnt_de = 0;
      cnt_fs = 0;
      for (int j = 0; j < tbl[i].n; j++) begin
        rr = tbl[i].r;
        ii = tbl[i].in;
        if (tbl[i].mode >= 1) ii = 1'($urandom_range(0, 1));
        if (tbl[i].mode == 2) rr = ($urandom_range(0, 63) == 0);
        cyc(rr, ii);
        if (o_de) cnt_de++;
        if (o_frame_start) cnt_fs++;
      end
      if (tbl[i].exp_de >= 0) begin
        checks++;
        if (cnt_de != tbl[i].exp_de || cnt_fs != tbl[i].exp_fs) begin
          errors++;
          $display("FAIL phase%0d de=%0d fs=%0d required de=%0d fs=%0d",
                   i, cnt_de, cnt_fs, tbl[i].exp_de, tbl[i].exp_fs);
        end
      end
    end

    // Reset in the middle of a visible line, then restart
    for (int j = 0; j < 3; j++) cyc(0, 1);
    found = 0;
    for (int j = 0; j < 3 * FT; j++) begin
      cyc(0, 0);
      if (o_rd_en && o_rd_x == 9'd3 && o_rd_y == 8'd2) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midframe_wait timeout actual=0 required=1");
    end
    cyc(1, 0);
    act_v = {o_rd_en, o_rd_x, o_rd_y, o_rgb, o_de,
             o_hsync, o_vsync, o_frame_start, o_frame_cnt};
    checks++;
    if (act_v !== {1'b0, 9'd0, 8'd0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_values actual=%h required=%h", act_v,
               {1'b0, 9'd0, 8'd0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
    end
    cyc(0, 1);
    cyc(0, 0);
    checks++;
    if (!(o_rd_en === 1'b1 && o_rd_x === 9'd0 && o_rd_y === 8'd0)) begin
      errors++;
      $display("FAIL restart_addr actual=%b/%0d/%0d required=1/0/0",
               o_rd_en, o_rd_x, o_rd_y);
    end

    // 257+ frames: pulse spacing and counter wrap
    last_fs = -1;
    npulses = 0;
    wrapped = 0;
    prev_fc = o_frame_cnt;
    for (int j = 0; j < 257 * FT + 8; j++) begin
      cyc(0, 0);
      if (o_frame_start) begin
        npulses++;
        if (last_fs >= 0) begin
          checks++;
          if (j - last_fs != FT) begin
            errors++;
            $display("FAIL fs_period actual=%0d required=%0d",
                     j - last_fs, FT);
          end
        end
        last_fs = j;
      end
      if (prev_fc == 8'd255 && o_frame_cnt == 8'd0) wrapped = 1;
      prev_fc = o_frame_cnt;
    end
    checks++;
    if (!wrapped || npulses != 258) begin
      errors++;
      $display("FAIL wrap_pulses wrapped=%0d pulses=%0d required 1/258",
               wrapped, npulses);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
